// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS-54 control path: sequencer state encoding,
// exception cause codes and default fetch addresses.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_WAIT = 2'd1,
        ST_EXC     = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    localparam logic [4:0] CAUSE_ADEL    = 5'd4;
    localparam logic [4:0] CAUSE_SYSCALL = 5'd8;
    localparam logic [4:0] CAUSE_BREAK   = 5'd9;
    localparam logic [4:0] CAUSE_TEQ     = 5'd13;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0040_0004;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between decode/ALU results, the PC register and the PC sequencer.
// master = decode side driving requests, slave = the sequencer.
interface pc_sequencer_if;

    logic [31:0] pc_cur;
    logic        br_taken;
    logic [15:0] br_imm;
    logic        jmp;
    logic [25:0] jmp_index;
    logic        jr;
    logic [31:0] rs_val;
    logic        eret;
    logic        exc_req;
    logic [4:0]  exc_cause;
    logic        md_start;
    logic        md_done;
    logic        halt;

    logic        pc_ena;
    logic [31:0] pc_next;
    logic [31:0] epc_out;
    logic [4:0]  cause_out;
    logic        exl_out;
    logic        md_timeout;
    logic [1:0]  state_out;

    modport master (
        output pc_cur, br_taken, br_imm, jmp, jmp_index, jr, rs_val,
               eret, exc_req, exc_cause, md_start, md_done, halt,
        input  pc_ena, pc_next, epc_out, cause_out, exl_out, md_timeout,
               state_out
    );

    modport slave (
        input  pc_cur, br_taken, br_imm, jmp, jmp_index, jr, rs_val,
               eret, exc_req, exc_cause, md_start, md_done, halt,
        output pc_ena, pc_next, epc_out, cause_out, exl_out, md_timeout,
               state_out
    );

endinterface

// File: rtl/pc_sequencer_npc_calc.sv
// Candidate next-PC arithmetic: sequential, branch and jump targets.
// All sums wrap modulo 2^32.
module npc_calc (
    input  logic [31:0] pc_cur,
    input  logic [15:0] br_imm,
    input  logic [25:0] jmp_index,
    output logic [31:0] pc4,
    output logic [31:0] br_target,
    output logic [31:0] jmp_target
);

    assign pc4        = pc_cur + 32'd4;
    assign br_target  = pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
    assign jmp_target = {pc4[31:28], jmp_index, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: selects the next fetch address, stalls for
// mul/div, and handles exception entry/return with EPC/Cause holding.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_VECTOR    = DEFAULT_EXC_VECTOR,
    parameter int          MD_MAX_CYCLES = 64,
    parameter int          CNT_W         = 7
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);

    state_t             state;
    logic [31:0]        epc;
    logic [4:0]         cause;
    logic               exl;
    logic               timeout_flag;
    logic [CNT_W-1:0]   wait_cnt;

    logic [31:0]        pc4;
    logic [31:0]        br_target;
    logic [31:0]        jmp_target;
    logic               jr_misaligned;
    logic               exc_live;
    logic               take_exc;
    logic [CNT_W-1:0]   cnt_inc;
    logic               at_limit;
    logic               pc_ena;
    logic [31:0]        pc_next;

    npc_calc u_npc_calc (
        .pc_cur     (bus.pc_cur),
        .br_imm     (bus.br_imm),
        .jmp_index  (bus.jmp_index),
        .pc4        (pc4),
        .br_target  (br_target),
        .jmp_target (jmp_target)
    );

    // A trap request is masked while already in an exception; a bad jr target
    // still faults because fetching it would be an address error regardless.
    assign jr_misaligned = bus.jr && (bus.rs_val[1:0] != 2'b00);
    assign exc_live      = bus.exc_req && !exl;
    assign take_exc      = exc_live || jr_misaligned;

    // Exit fires on the cycle whose increment reaches the limit.
    assign cnt_inc  = wait_cnt + CNT_W'(1);
    assign at_limit = (cnt_inc == CNT_W'(MD_MAX_CYCLES - 1));

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        pc_ena  = 1'b0;
        pc_next = pc4;
        unique case (state)
            ST_RUN: begin
                if (bus.halt || take_exc) begin
                    pc_ena = 1'b0;
                end else if (bus.eret) begin
                    pc_ena  = 1'b1;
                    pc_next = epc + 32'd4;
                end else if (bus.jr) begin
                    pc_ena  = 1'b1;
                    pc_next = bus.rs_val;
                end else if (bus.jmp) begin
                    pc_ena  = 1'b1;
                    pc_next = jmp_target;
                end else if (bus.br_taken) begin
                    pc_ena  = 1'b1;
                    pc_next = br_target;
                end else if (bus.md_start) begin
                    pc_ena = 1'b0;
                end else begin
                    pc_ena = 1'b1;
                end
            end
            ST_MD_WAIT: pc_ena = bus.md_done || at_limit;
            ST_EXC: begin
                pc_ena  = 1'b1;
                pc_next = EXC_VECTOR;
            end
            ST_HALT: pc_ena = 1'b0;
            default: pc_ena = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            epc          <= RESET_PC;
            cause        <= 5'd0;
            exl          <= 1'b0;
            timeout_flag <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (bus.halt) begin
                        state <= ST_HALT;
                    end else if (take_exc) begin
                        epc   <= bus.pc_cur;
                        cause <= exc_live ? bus.exc_cause : CAUSE_ADEL;
                        exl   <= 1'b1;
                        state <= ST_EXC;
                    end else if (bus.eret) begin
                        exl <= 1'b0;
                    end else if (!bus.jr && !bus.jmp && !bus.br_taken && bus.md_start) begin
                        wait_cnt <= '0;
                        state    <= ST_MD_WAIT;
                    end
                end
                ST_MD_WAIT: begin
                    wait_cnt <= cnt_inc;
                    if (bus.md_done) begin
                        state <= ST_RUN;
                    end else if (at_limit) begin
                        timeout_flag <= 1'b1;
                        state        <= ST_RUN;
                    end
                end
                ST_EXC:  state <= ST_RUN;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_RUN;
            endcase
        end
    end

    assign bus.pc_ena     = pc_ena;
    assign bus.pc_next    = pc_next;
    assign bus.epc_out    = epc;
    assign bus.cause_out  = cause;
    assign bus.exl_out    = exl;
    assign bus.md_timeout = timeout_flag;
    assign bus.state_out  = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: sequential/wrap, branch and
// jump targets, exception round trip, misaligned jr, mul/div wait and halt.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_PC      (32'h0040_0000),
        .EXC_VECTOR    (32'h0040_0004),
        .MD_MAX_CYCLES (64),
        .CNT_W         (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Inputs change 1 time unit after a rising edge; comb outputs are read 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        bus.pc_cur    = 32'h0;
        bus.br_taken  = 1'b0;
        bus.br_imm    = 16'h0;
        bus.jmp       = 1'b0;
        bus.jmp_index = 26'h0;
        bus.jr        = 1'b0;
        bus.rs_val    = 32'h0;
        bus.eret      = 1'b0;
        bus.exc_req   = 1'b0;
        bus.exc_cause = 5'd0;
        bus.md_start  = 1'b0;
        bus.md_done   = 1'b0;
        bus.halt      = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Starts a mul/div wait at pc; md_done is pulsed on wait cycle done_at (-1 = never).
    // halt and exc_req are held high during the wait to show they are ignored.
    task automatic run_md(input logic [31:0] pc, input int done_at, output int low,
                          output bit exited, output logic [31:0] exit_next);
        low       = 0;
        exited    = 1'b0;
        exit_next = 32'h0;
        bus.pc_cur   = pc;
        bus.md_start = 1'b1;
        settle();
        if (!bus.pc_ena) low++;
        tick();
        bus.md_start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            bus.md_done   = (k == done_at);
            bus.halt      = 1'b1;
            bus.exc_req   = 1'b1;
            bus.exc_cause = 5'd9;
            settle();
            if (bus.pc_ena) begin
                exited    = 1'b1;
                exit_next = bus.pc_next;
            end else begin
                low++;
            end
            tick();
            if (exited) break;
        end
        clear_inputs();
        bus.pc_cur = pc;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.halt    = 1'b1;
        bus.exc_req = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_inputs();
        checks++; if (bus.state_out !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", bus.state_out); end
        checks++; if (bus.epc_out !== 32'h0040_0000) begin failures++; $display("FAIL reset_epc: got %h expected 00400000", bus.epc_out); end
        checks++; if (bus.cause_out !== 5'd0) begin failures++; $display("FAIL reset_cause: got %0d expected 0", bus.cause_out); end
        checks++; if (bus.exl_out !== 1'b0) begin failures++; $display("FAIL reset_exl: got %b expected 0", bus.exl_out); end
        checks++; if (bus.md_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b expected 0", bus.md_timeout); end
    endtask

    task automatic test_sequential();
        bus.pc_cur = 32'h0040_0000;
        settle();
        checks++; if (bus.pc_ena !== 1'b1) begin failures++; $display("FAIL seq_ena: got %b expected 1", bus.pc_ena); end
        checks++; if (bus.pc_next !== 32'h0040_0004) begin failures++; $display("FAIL seq_next: got %h expected 00400004", bus.pc_next); end
        tick();
        bus.pc_cur = 32'hFFFF_FFFC;
        settle();
        checks++; if (bus.pc_next !== 32'h0000_0000) begin failures++; $display("FAIL seq_wrap: got %h expected 00000000", bus.pc_next); end
        tick();
    endtask

    task automatic test_branch_jump();
        bus.pc_cur   = 32'h0040_0010;
        bus.br_taken = 1'b1;
        bus.br_imm   = 16'hFFFE;
        settle();
        checks++; if (bus.pc_next !== 32'h0040_000C || bus.pc_ena !== 1'b1) begin failures++; $display("FAIL branch_back: got %h ena %b expected 0040000c ena 1", bus.pc_next, bus.pc_ena); end
        tick();
        bus.br_imm = 16'h0010;
        settle();
        checks++; if (bus.pc_next !== 32'h0040_0054) begin failures++; $display("FAIL branch_fwd: got %h expected 00400054", bus.pc_next); end
        tick();
        bus.br_taken  = 1'b0;
        bus.jmp       = 1'b1;
        bus.jmp_index = 26'h010_0010;
        settle();
        checks++; if (bus.pc_next !== 32'h0040_0040) begin failures++; $display("FAIL jump: got %h expected 00400040", bus.pc_next); end
        tick();
        bus.br_taken = 1'b1;
        bus.br_imm   = 16'hFFFE;
        settle();
        checks++; if (bus.pc_next !== 32'h0040_0040) begin failures++; $display("FAIL jump_over_branch: got %h expected 00400040", bus.pc_next); end
        tick();
        bus.jr     = 1'b1;
        bus.rs_val = 32'h0040_0100;
        settle();
        checks++; if (bus.pc_next !== 32'h0040_0100 || bus.pc_ena !== 1'b1) begin failures++; $display("FAIL jr_over_jump: got %h ena %b expected 00400100 ena 1", bus.pc_next, bus.pc_ena); end
        tick();
        clear_inputs();
        checks++; if (bus.state_out !== 2'd0) begin failures++; $display("FAIL branch_state: got %0d expected 0", bus.state_out); end
    endtask

    task automatic test_exception();
        apply_reset();
        bus.pc_cur    = 32'h0040_0020;
        bus.exc_req   = 1'b1;
        bus.exc_cause = 5'd8;
        bus.md_start  = 1'b1;
        settle();
        checks++; if (bus.pc_ena !== 1'b0) begin failures++; $display("FAIL exc_entry_ena: got %b expected 0", bus.pc_ena); end
        tick();
        clear_inputs();
        checks++; if (bus.state_out !== 2'd2) begin failures++; $display("FAIL exc_state: got %0d expected 2", bus.state_out); end
        checks++; if (bus.epc_out !== 32'h0040_0020) begin failures++; $display("FAIL exc_epc: got %h expected 00400020", bus.epc_out); end
        checks++; if (bus.cause_out !== 5'd8) begin failures++; $display("FAIL exc_cause: got %0d expected 8", bus.cause_out); end
        checks++; if (bus.exl_out !== 1'b1) begin failures++; $display("FAIL exc_exl: got %b expected 1", bus.exl_out); end
        settle();
        checks++; if (bus.pc_next !== 32'h0040_0004 || bus.pc_ena !== 1'b1) begin failures++; $display("FAIL exc_vector: got %h ena %b expected 00400004 ena 1", bus.pc_next, bus.pc_ena); end
        tick();
        bus.pc_cur    = 32'h0040_0004;
        bus.exc_req   = 1'b1;
        bus.exc_cause = 5'd9;
        settle();
        checks++; if (bus.pc_next !== 32'h0040_0008 || bus.pc_ena !== 1'b1) begin failures++; $display("FAIL nested_ignored: got %h ena %b expected 00400008 ena 1", bus.pc_next, bus.pc_ena); end
        tick();
        checks++; if (bus.state_out !== 2'd0 || bus.cause_out !== 5'd8 || bus.epc_out !== 32'h0040_0020) begin failures++; $display("FAIL nested_hold: state %0d cause %0d epc %h expected 0 8 00400020", bus.state_out, bus.cause_out, bus.epc_out); end
        bus.exc_req = 1'b0;
        bus.pc_cur  = 32'h0040_0008;
        bus.eret    = 1'b1;
        settle();
        checks++; if (bus.pc_next !== 32'h0040_0024 || bus.pc_ena !== 1'b1) begin failures++; $display("FAIL eret_next: got %h ena %b expected 00400024 ena 1", bus.pc_next, bus.pc_ena); end
        tick();
        clear_inputs();
        checks++; if (bus.exl_out !== 1'b0) begin failures++; $display("FAIL eret_exl: got %b expected 0", bus.exl_out); end
    endtask

    task automatic test_misaligned_jr();
        apply_reset();
        bus.pc_cur = 32'h0040_0030;
        bus.jr     = 1'b1;
        bus.rs_val = 32'h0040_0002;
        settle();
        checks++; if (bus.pc_ena !== 1'b0) begin failures++; $display("FAIL badjr_ena: got %b expected 0", bus.pc_ena); end
        tick();
        clear_inputs();
        checks++; if (bus.state_out !== 2'd2 || bus.cause_out !== 5'd4) begin failures++; $display("FAIL badjr_exc: state %0d cause %0d expected 2 4", bus.state_out, bus.cause_out); end
        checks++; if (bus.epc_out !== 32'h0040_0030) begin failures++; $display("FAIL badjr_epc: got %h expected 00400030", bus.epc_out); end
        settle();
        checks++; if (bus.pc_next !== 32'h0040_0004 || bus.pc_ena !== 1'b1) begin failures++; $display("FAIL badjr_vector: got %h ena %b expected 00400004 ena 1", bus.pc_next, bus.pc_ena); end
        tick();
    endtask

    task automatic test_md_wait();
        int low; bit exited; logic [31:0] nxt;
        apply_reset();
        run_md(32'h0040_0050, 9, low, exited, nxt);
        checks++; if (!exited) begin failures++; $display("FAIL md_done_exit: no exit within budget"); end
        checks++; if (low !== 10) begin failures++; $display("FAIL md_done_stall: got %0d low cycles expected 10", low); end
        checks++; if (nxt !== 32'h0040_0054) begin failures++; $display("FAIL md_done_next: got %h expected 00400054", nxt); end
        checks++; if (bus.state_out !== 2'd0 || bus.exl_out !== 1'b0 || bus.md_timeout !== 1'b0) begin failures++; $display("FAIL md_done_after: state %0d exl %b timeout %b expected 0 0 0", bus.state_out, bus.exl_out, bus.md_timeout); end
    endtask

    task automatic test_md_done_at_limit();
        int low; bit exited; logic [31:0] nxt;
        apply_reset();
        run_md(32'h0040_0058, 62, low, exited, nxt);
        checks++; if (low !== 63 || !exited) begin failures++; $display("FAIL md_limit_stall: got %0d low cycles exited %b expected 63 1", low, exited); end
        checks++; if (bus.md_timeout !== 1'b0) begin failures++; $display("FAIL md_limit_done: timeout %b expected 0", bus.md_timeout); end
    endtask

    task automatic test_md_timeout();
        int low; bit exited; logic [31:0] nxt;
        apply_reset();
        run_md(32'h0040_0060, -1, low, exited, nxt);
        checks++; if (low !== 63 || !exited) begin failures++; $display("FAIL md_timeout_stall: got %0d low cycles exited %b expected 63 1", low, exited); end
        checks++; if (nxt !== 32'h0040_0064) begin failures++; $display("FAIL md_timeout_next: got %h expected 00400064", nxt); end
        checks++; if (bus.md_timeout !== 1'b1 || bus.state_out !== 2'd0) begin failures++; $display("FAIL md_timeout_flag: timeout %b state %0d expected 1 0", bus.md_timeout, bus.state_out); end
        run_md(32'h0040_0068, 0, low, exited, nxt);
        checks++; if (bus.md_timeout !== 1'b1 || low !== 1) begin failures++; $display("FAIL md_timeout_sticky: timeout %b low %0d expected 1 1", bus.md_timeout, low); end
    endtask

    // Runs straight after the timeout test so md_timeout starts set.
    task automatic test_reset_mid_op();
        bus.pc_cur    = 32'h0040_0070;
        bus.exc_req   = 1'b1;
        bus.exc_cause = 5'd13;
        tick();
        clear_inputs();
        tick();
        bus.pc_cur   = 32'h0040_0080;
        bus.md_start = 1'b1;
        tick();
        bus.md_start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        checks++; if (bus.state_out !== 2'd1 || bus.exl_out !== 1'b1 || bus.cause_out !== 5'd13) begin failures++; $display("FAIL mid_pre: state %0d exl %b cause %0d expected 1 1 13", bus.state_out, bus.exl_out, bus.cause_out); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.state_out !== 2'd0) begin failures++; $display("FAIL mid_rst_state: got %0d expected 0", bus.state_out); end
        checks++; if (bus.epc_out !== 32'h0040_0000) begin failures++; $display("FAIL mid_rst_epc: got %h expected 00400000", bus.epc_out); end
        checks++; if (bus.md_timeout !== 1'b0 || bus.exl_out !== 1'b0 || bus.cause_out !== 5'd0) begin failures++; $display("FAIL mid_rst_flags: timeout %b exl %b cause %0d expected 0 0 0", bus.md_timeout, bus.exl_out, bus.cause_out); end
        settle();
        checks++; if (bus.pc_ena !== 1'b1 || bus.pc_next !== 32'h0040_0084) begin failures++; $display("FAIL mid_rst_resume: got %h ena %b expected 00400084 ena 1", bus.pc_next, bus.pc_ena); end
        tick();
    endtask

    task automatic test_halt();
        int bad;
        apply_reset();
        bus.pc_cur  = 32'h0040_0090;
        bus.halt    = 1'b1;
        bus.exc_req = 1'b1;
        settle();
        checks++; if (bus.pc_ena !== 1'b0) begin failures++; $display("FAIL halt_ena: got %b expected 0", bus.pc_ena); end
        tick();
        checks++; if (bus.state_out !== 2'd3 || bus.exl_out !== 1'b0) begin failures++; $display("FAIL halt_state: state %0d exl %b expected 3 0", bus.state_out, bus.exl_out); end
        bad = 0;
        bus.halt = 1'b0;
        for (int k = 0; k < 20; k++) begin
            bus.jmp     = k[0];
            bus.eret    = k[1];
            bus.exc_req = k[2];
            settle();
            if (bus.pc_ena !== 1'b0 || bus.state_out !== 2'd3) bad++;
            tick();
        end
        clear_inputs();
        checks++; if (bad !== 0) begin failures++; $display("FAIL halt_hold: got %0d bad cycles expected 0", bad); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.state_out !== 2'd0) begin failures++; $display("FAIL halt_rst: got %0d expected 0", bus.state_out); end
    endtask

    initial begin
        clear_inputs();
        tick();
        test_reset();
        test_sequential();
        test_branch_jump();
        test_exception();
        test_misaligned_jr();
        test_md_wait();
        test_md_done_at_limit();
        test_md_timeout();
        test_reset_mid_op();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
